// File: rtl/controlador_porta.sv
// Automatic door opener: motor-sequencing FSM around the open rule ~c & (h | p),
// with hold timer, obstruction reversal and latched fault on timeout or limit conflict.
module controlador_porta #(
    parameter int HOLD_CYCLES    = 16,
    parameter int MOTION_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic c,
    input  logic h,
    input  logic p,
    input  logic lim_open,
    input  logic lim_closed,
    output logic motor_open,
    output logic motor_close,
    output logic door_open,
    output logic fault
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int MW = $clog2(MOTION_TIMEOUT);

    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(1);
    localparam logic [MW-1:0] MOT_LAST  = MW'(MOTION_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_CLOSED,
        ST_OPENING,
        ST_OPEN,
        ST_CLOSING,
        ST_FAULT
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_nxt;
    logic [MW-1:0] mot_cnt;
    logic [MW-1:0] mot_nxt;

    logic pres;
    logic req;
    logic lim_conflict;

    assign pres         = h | p;
    assign req          = ~c & pres;
    assign lim_conflict = lim_open & lim_closed;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_CLOSED;
            hold_cnt <= '0;
            mot_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            hold_cnt <= hold_nxt;
            mot_cnt  <= mot_nxt;
        end
    end

    // Both limit switches active at once means broken wiring: fault from any state.
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        mot_nxt   = mot_cnt;

        if (lim_conflict) begin
            state_nxt = ST_FAULT;
        end else begin
            unique case (state)
                ST_CLOSED: begin
                    if (req) begin
                        state_nxt = ST_OPENING;
                        mot_nxt   = '0;
                    end
                end

                ST_OPENING: begin
                    if (lim_open) begin
                        state_nxt = ST_OPEN;
                        hold_nxt  = HOLD_LOAD;
                    end else if (mot_cnt == MOT_LAST) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        mot_nxt = mot_cnt + MW'(1);
                    end
                end

                // Presence keeps the door open even when locked; lock only shortens the hold.
                ST_OPEN: begin
                    if (pres) begin
                        hold_nxt = HOLD_LOAD;
                    end else if (c || hold_cnt == HOLD_LAST) begin
                        state_nxt = ST_CLOSING;
                        mot_nxt   = '0;
                    end else begin
                        hold_nxt = hold_cnt - HW'(1);
                    end
                end

                // Reversal is checked before the closed limit so a person is never trapped.
                ST_CLOSING: begin
                    if (pres) begin
                        state_nxt = ST_OPENING;
                        mot_nxt   = '0;
                    end else if (lim_closed) begin
                        state_nxt = ST_CLOSED;
                    end else if (mot_cnt == MOT_LAST) begin
                        state_nxt = ST_FAULT;
                    end else begin
                        mot_nxt = mot_cnt + MW'(1);
                    end
                end

                ST_FAULT: begin
                    state_nxt = ST_FAULT;
                end

                default: begin
                    state_nxt = ST_FAULT;
                end
            endcase
        end
    end

    assign motor_open  = (state == ST_OPENING);
    assign motor_close = (state == ST_CLOSING);
    assign door_open   = (state == ST_OPEN);
    assign fault       = (state == ST_FAULT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(motor_open && motor_close));
        end
    end

endmodule
